// File: rtl/alu_decode_stage.sv
// Decode/operand-fetch stage feeding the RV32I ALU.
// Holds the register file and one registered valid/ready output slot.
module alu_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_alu_op,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1000;
    localparam logic [3:0] ALU_SLT  = 4'b1001;

    typedef struct packed {
        logic [3:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            illegal;
    } bundle_t;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd_f;

    assign opcode = in_instr[6:0];
    assign rd_f   = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];

    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;

    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_u = {in_instr[31:12], {(XLEN-20){1'b0}}};
    assign shamt = {{(XLEN-5){1'b0}}, in_instr[24:20]};

    // Register file; reset wins over a same-cycle writeback.
    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && (wb_rd != 5'd0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

    always_comb begin
        rs1_val = regs[rs1];
        if (rs1 == 5'd0) begin
            rs1_val = '0;
        end else if (wb_en && (wb_rd == rs1)) begin
            rs1_val = wb_data;
        end
    end

    always_comb begin
        rs2_val = regs[rs2];
        if (rs2 == 5'd0) begin
            rs2_val = '0;
        end else if (wb_en && (wb_rd == rs2)) begin
            rs2_val = wb_data;
        end
    end

    bundle_t nxt;
    logic    bad;

    always_comb begin
        nxt         = '0;
        nxt.rd      = rd_f;
        bad         = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                nxt.a = rs1_val;
                nxt.b = rs2_val;
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'b000: nxt.op = ALU_ADD;
                        3'b001: nxt.op = ALU_SLL;
                        3'b010: nxt.op = ALU_SLT;
                        3'b011: nxt.op = ALU_SLTU;
                        3'b100: nxt.op = ALU_XOR;
                        3'b101: nxt.op = ALU_SRL;
                        3'b110: nxt.op = ALU_OR;
                        3'b111: nxt.op = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    nxt.op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    nxt.op = ALU_SRA;
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_IMM: begin
                nxt.a = rs1_val;
                nxt.b = imm_i;
                unique case (funct3)
                    3'b000: nxt.op = ALU_ADD;
                    3'b010: nxt.op = ALU_SLT;
                    3'b011: nxt.op = ALU_SLTU;
                    3'b100: nxt.op = ALU_XOR;
                    3'b110: nxt.op = ALU_OR;
                    3'b111: nxt.op = ALU_AND;
                    3'b001: begin
                        nxt.b  = shamt;
                        nxt.op = ALU_SLL;
                        bad    = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        nxt.b = shamt;
                        if (funct7 == F7_BASE) begin
                            nxt.op = ALU_SRL;
                        end else if (funct7 == F7_ALT) begin
                            nxt.op = ALU_SRA;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                endcase
            end
            OPC_LUI: begin
                nxt.a  = '0;
                nxt.b  = imm_u;
                nxt.op = ALU_ADD;
            end
            default: bad = 1'b1;
        endcase
        // Illegal bundles still travel downstream, but carry no payload.
        if (bad) begin
            nxt         = '0;
            nxt.illegal = 1'b1;
        end
    end

    bundle_t q;
    logic    valid_q;
    logic    accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            q       <= '0;
        end else begin
            if (in_ready) begin
                valid_q <= in_valid;
            end
            if (accept) begin
                q <= nxt;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_a       = q.a;
    assign out_b       = q.b;
    assign out_alu_op  = q.op;
    assign out_rd      = q.rd;
    assign out_illegal = q.illegal;

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode/operand-fetch stage that sits directly upstream of the RV32I ALU. It holds the 32x32 integer register file and decodes OP, OP-IMM and LUI instructions into the ALU's 4-bit `alu_op` code and two 32-bit operands. Results are presented through a single registered valid/ready output stage that feeds the ALU/execute stage. Writeback enters through a dedicated write port with same-cycle bypass.

## Interface
- `XLEN`, 32: datapath width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  stage can accept an instruction this cycle.
- `in_instr`  in  32  RV32I instruction word.
- `wb_en`  in  1  register-file write enable.
- `wb_rd`  in  5  write address.
- `wb_data`  in  32  write data.
- `out_valid`  out  1  decoded bundle valid.
- `out_ready`  in  1  downstream accepts the bundle.
- `out_a`  out  32  ALU operand A.
- `out_b`  out  32  ALU operand B.
- `out_alu_op`  out  4  ALU op code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 SLTU, 1001 SLT.
- `out_rd`  out  5  destination register.
- `out_illegal`  out  1  instruction is not a supported ALU instruction.

## Operation
- Register file: 32 entries, all cleared to 0 by `rst`.
  - `wb_en` with `wb_rd`≠0 writes `wb_data` at the clock edge.
  - Writes to x0 are ignored; reads of x0 always return 0.
- Operand read happens in the accept cycle. Bypass rule: if `wb_en` is set, `wb_rd`==rs, and rs≠0, the read returns `wb_data`.
- OP (opcode 0110011): A=rs1, B=rs2. Mapping by funct3/funct7:
  - 000/0000000 ADD; 000/0100000 SUB
  - 001/0000000 SLL
  - 010/0000000 SLT; 011/0000000 SLTU
  - 100/0000000 XOR
  - 101/0000000 SRL; 101/0100000 SRA
  - 110/0000000 OR; 111/0000000 AND
  - Any other funct7 is illegal.
- OP-IMM (opcode 0010011): A=rs1.
  - B is the sign-extended `instr[31:20]` for ADDI, SLTI, SLTIU, XORI, ORI and ANDI. SLTIU compares against this sign-extended value as unsigned.
  - SLLI requires `instr[31:25]`=0.
  - SRLI requires `instr[31:25]`=0; SRAI requires `instr[31:25]`=0100000.
  - For shifts, B = {27'b0, `instr[24:20]`}. Any other `instr[31:25]` is illegal.
- LUI (opcode 0110111): A=0, B={`instr[31:12]`, 12'b0}, op ADD.
- Illegal or unsupported opcode: `out_illegal`=1, `out_alu_op`=0000, A=B=0, `out_rd`=0. The bundle is still delivered through the handshake.
- `out_rd` = `instr[11:7]` for legal instructions.

## Timing
- Reset values: `out_valid`=0, `out_a`=`out_b`=0, `out_alu_op`=0000, `out_rd`=0, `out_illegal`=0, all registers 0. `in_ready`=1 in the first cycle after reset.
- `in_ready` = !`out_valid` || `out_ready`. This is combinational; `in_ready` does not depend on `in_valid`.
- An instruction is accepted when `in_valid` && `in_ready`. Its bundle appears on the next edge with `out_valid`=1. Latency is 1 cycle.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Stall (`out_valid` && !`out_ready`):
  - The output bundle holds bit-stable and `in_ready`=0.
  - Writebacks during the stall update the register file but not the held operands.
- Simultaneous output drain and input accept: the new bundle replaces the old one on the same edge, with no bubble.
- `out_valid` falls the cycle after a drain if no new accept occurs.
- `rst` asserted mid-stall: the bundle is dropped, the outputs take their reset values next cycle, and a same-cycle writeback is discarded.

## Test plan
- Reset, then writeback x1=10 and x2=5 on two cycles. Issue ADD x3,x1,x2, then SUB → bundles A=0000000A B=00000005 op 0000, then op 0001, each 1 cycle after accept, rd=3.
- Bypass: `wb_en` x5=FF00FF00 in the same cycle as accepting XOR x6,x5,x0 → A=FF00FF00, B=0, op 0100. Also write x0=1234 then read x0 → 0.
- Immediates:
  - SRAI x7,x1,2 → B=00000002, op 0111.
  - ADDI imm=0xFFF → B=FFFFFFFF, op 0000.
  - LUI imm=0x12345 → A=0, B=12345000.
- Illegal cases: SLLI with `instr[31:25]`=0100000, and opcode 1100011 → `out_illegal`=1, op 0000, A=B=0, rd=0.
- Backpressure:
  - Hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, bundle stable, no instruction lost.
  - Release `out_ready` → back-to-back bundles at 1/cycle in order.
- Assert `rst` during a stall → next cycle `out_valid`=0 and operands 0. A subsequent read of x1 returns 0.
